// File: rtl/framebuffer_scanout_pkg.sv
// Shared types and default VGA timing for the frame buffer scanout block.
package framebuffer_scanout_pkg;

  // One RGB444 pixel as stored in the frame buffer (red in the top nibble).
  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  // 640x480@60 timing, in pixel clocks and lines.
  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;

  localparam int VGA_H_TOTAL      = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int VGA_V_TOTAL      = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;
  localparam int VGA_H_SYNC_START = VGA_H_VISIBLE + VGA_H_FRONT;
  localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC;
  localparam int VGA_V_SYNC_START = VGA_V_VISIBLE + VGA_V_FRONT;
  localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC;

  // Draw handshake: waiting for the first vblank, running, one-cycle swap.
  typedef enum logic [1:0] {
    ST_INIT,
    ST_RUN,
    ST_SWAP
  } scanout_state_t;

endpackage

// File: rtl/framebuffer_scanout_vga_timing.sv
// Horizontal/vertical counters and the raw (unaligned) timing strobes.
module framebuffer_scanout_vga_timing
  import framebuffer_scanout_pkg::*;
#(
  parameter int H_VISIBLE = VGA_H_VISIBLE,
  parameter int H_FRONT   = VGA_H_FRONT,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BACK    = VGA_H_BACK,
  parameter int V_VISIBLE = VGA_V_VISIBLE,
  parameter int V_FRONT   = VGA_V_FRONT,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BACK    = VGA_V_BACK,
  parameter int HW        = $clog2(H_VISIBLE + H_FRONT + H_SYNC + H_BACK),
  parameter int VW        = $clog2(V_VISIBLE + V_FRONT + V_SYNC + V_BACK)
) (
  input  logic          clk,
  input  logic          rstn,
  output logic [HW-1:0] h_count,
  output logic [VW-1:0] v_count,
  output logic          line_end,
  output logic          frame_end,
  output logic          visible,
  output logic          hsync_raw,
  output logic          vsync_raw,
  output logic          vblank_start
);

  localparam int H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  assign line_end  = (h_count == HW'(H_TOTAL - 1));
  assign frame_end = line_end && (v_count == VW'(V_TOTAL - 1));

  // Pixel and line counters; v advances on every h wrap.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      h_count <= '0;
      v_count <= '0;
    end else if (line_end) begin
      h_count <= '0;
      v_count <= frame_end ? '0 : v_count + VW'(1);
    end else begin
      h_count <= h_count + HW'(1);
    end
  end

  // Strobes decoded straight from the registered counters (sync already active-low).
  assign visible      = (h_count < HW'(H_VISIBLE)) && (v_count < VW'(V_VISIBLE));
  assign hsync_raw    = !((h_count >= HW'(H_SYNC_START)) && (h_count < HW'(H_SYNC_END)));
  assign vsync_raw    = !((v_count >= VW'(V_SYNC_START)) && (v_count < VW'(V_SYNC_END)));
  assign vblank_start = (h_count == '0) && (v_count == VW'(V_VISIBLE));

endmodule

// File: rtl/framebuffer_scanout.sv
// Frame buffer reader: VGA timing, 4x4 upscaled readout of the front buffer,
// and the buffer-swap handshake with the drawing side.
module framebuffer_scanout
  import framebuffer_scanout_pkg::*;
#(
  parameter int BUFFER_WIDTH      = 160,
  parameter int BUFFER_HEIGHT     = 120,
  parameter int BUFFER_DATA_WIDTH = 12,
  parameter int BUFFER_ADDR_WIDTH = $clog2(BUFFER_WIDTH * BUFFER_HEIGHT),
  parameter int SCALE             = 4,
  parameter int H_VISIBLE         = VGA_H_VISIBLE,
  parameter int H_FRONT           = VGA_H_FRONT,
  parameter int H_SYNC            = VGA_H_SYNC,
  parameter int H_BACK            = VGA_H_BACK,
  parameter int V_VISIBLE         = VGA_V_VISIBLE,
  parameter int V_FRONT           = VGA_V_FRONT,
  parameter int V_SYNC            = VGA_V_SYNC,
  parameter int V_BACK            = VGA_V_BACK
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         frame_done,
  output logic                         draw_start,
  output logic                         draw_ack,
  output logic                         buffer_select,
  output logic                         read_en,
  output logic                         read_buffer,
  output logic [BUFFER_ADDR_WIDTH-1:0] read_addr,
  input  logic [BUFFER_DATA_WIDTH-1:0] read_data,
  output logic                         vga_hsync,
  output logic                         vga_vsync,
  output logic [3:0]                   vga_r,
  output logic [3:0]                   vga_g,
  output logic [3:0]                   vga_b
);

  localparam int AW    = BUFFER_ADDR_WIDTH;
  localparam int SHIFT = $clog2(SCALE);
  localparam int HW    = $clog2(H_VISIBLE + H_FRONT + H_SYNC + H_BACK);
  localparam int VW    = $clog2(V_VISIBLE + V_FRONT + V_SYNC + V_BACK);

  logic [HW-1:0]  h_count;
  logic [VW-1:0]  v_count;
  logic           line_end;
  logic           frame_end;
  logic           visible;
  logic           hsync_raw;
  logic           vsync_raw;
  logic           vblank_start;

  framebuffer_scanout_vga_timing #(
    .H_VISIBLE (H_VISIBLE),
    .H_FRONT   (H_FRONT),
    .H_SYNC    (H_SYNC),
    .H_BACK    (H_BACK),
    .V_VISIBLE (V_VISIBLE),
    .V_FRONT   (V_FRONT),
    .V_SYNC    (V_SYNC),
    .V_BACK    (V_BACK),
    .HW        (HW),
    .VW        (VW)
  ) u_timing (
    .clk          (clk),
    .rstn         (rstn),
    .h_count      (h_count),
    .v_count      (v_count),
    .line_end     (line_end),
    .frame_end    (frame_end),
    .visible      (visible),
    .hsync_raw    (hsync_raw),
    .vsync_raw    (vsync_raw),
    .vblank_start (vblank_start)
  );

  // ---------------------------------------------------------------- stage 0
  logic [AW-1:0] line_base;

  // First address of the current source row; steps by one row every SCALE lines.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      line_base <= '0;
    end else if (frame_end) begin
      line_base <= '0;
    end else if (line_end && (v_count < VW'(V_VISIBLE)) &&
                 (v_count[SHIFT-1:0] == {SHIFT{1'b1}})) begin
      line_base <= line_base + AW'(BUFFER_WIDTH);
    end
  end

  // Counters sit at h=0,v=0 during reset, which decodes as visible; gate the
  // enable so no read is issued while reset is held.
  assign read_en   = visible && rstn;
  assign read_addr = visible ? (AW'(h_count >> SHIFT) + line_base) : '0;

  // ---------------------------------------------------------------- stage 1
  logic hsync_d1;
  logic vsync_d1;
  logic visible_d1;

  // Delay the strobes one cycle to line up with the registered BRAM data.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hsync_d1   <= 1'b1;
      vsync_d1   <= 1'b1;
      visible_d1 <= 1'b0;
    end else begin
      hsync_d1   <= hsync_raw;
      vsync_d1   <= vsync_raw;
      visible_d1 <= visible;
    end
  end

  // ---------------------------------------------------------------- stage 2
  rgb444_t rgb_q;

  // Registered pins: colour is forced black outside the visible area.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vga_hsync <= 1'b1;
      vga_vsync <= 1'b1;
      rgb_q     <= '0;
    end else begin
      vga_hsync <= hsync_d1;
      vga_vsync <= vsync_d1;
      rgb_q     <= visible_d1 ? rgb444_t'(read_data) : '0;
    end
  end

  assign vga_r = rgb_q.r;
  assign vga_g = rgb_q.g;
  assign vga_b = rgb_q.b;

  // ------------------------------------------------------------- handshake
  scanout_state_t state;
  scanout_state_t next_state;
  logic           swap_pending;

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_INIT;
    else       state <= next_state;
  end

  // Next-state logic: swaps are only taken on the vblank_start cycle.
  // NOTE: always_comb assigns a default first so no path leaves a latch behind.
  always_comb begin
    next_state = state;
    unique case (state)
      ST_INIT: if (vblank_start) next_state = ST_RUN;
      ST_RUN:  if (vblank_start && (swap_pending || frame_done)) next_state = ST_SWAP;
      ST_SWAP: next_state = ST_RUN;
      default: next_state = ST_INIT;
    endcase
  end

  // Output decode: draw_start on the first vblank, draw_ack while swapping.
  always_comb begin
    draw_start = 1'b0;
    draw_ack   = 1'b0;
    unique case (state)
      ST_INIT: draw_start = vblank_start;
      ST_SWAP: draw_ack   = 1'b1;
      default: ;
    endcase
  end

  // Remembers a frame_done seen mid-frame until the next vblank swap.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                           swap_pending <= 1'b0;
    else if (state == ST_SWAP)           swap_pending <= 1'b0;
    else if (state == ST_RUN && frame_done) swap_pending <= 1'b1;
  end

  // Flip the buffers as the FSM enters SWAP, so the change lands in vblank.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                         buffer_select <= 1'b0;
    else if (state == ST_RUN && next_state == ST_SWAP) buffer_select <= ~buffer_select;
  end

  assign read_buffer = ~buffer_select;

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Scoreboard bench for framebuffer_scanout on a shrunken 64x48 raster
// (16x12 source, 4x upscale) so that several frames fit in a short run.
module tb_framebuffer_scanout;

  localparam int BW = 16;
  localparam int BH = 12;
  localparam int SC = 4;
  localparam int AW = 8;
  localparam int HV = 64, HF = 4, HS = 8, HB = 4;
  localparam int VV = 48, VF = 2, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int MAX_CYCLES = 60000;

  logic          clk = 1'b0;
  logic          rstn;
  logic          frame_done;
  logic          draw_start;
  logic          draw_ack;
  logic          buffer_select;
  logic          read_en;
  logic          read_buffer;
  logic [AW-1:0] read_addr;
  logic [11:0]   read_data = '0;
  logic          vga_hsync;
  logic          vga_vsync;
  logic [3:0]    vga_r;
  logic [3:0]    vga_g;
  logic [3:0]    vga_b;

  framebuffer_scanout #(
    .BUFFER_WIDTH      (BW),
    .BUFFER_HEIGHT     (BH),
    .BUFFER_DATA_WIDTH (12),
    .BUFFER_ADDR_WIDTH (AW),
    .SCALE             (SC),
    .H_VISIBLE         (HV),
    .H_FRONT           (HF),
    .H_SYNC            (HS),
    .H_BACK            (HB),
    .V_VISIBLE         (VV),
    .V_FRONT           (VF),
    .V_SYNC            (VS),
    .V_BACK            (VB)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .frame_done    (frame_done),
    .draw_start    (draw_start),
    .draw_ack      (draw_ack),
    .buffer_select (buffer_select),
    .read_en       (read_en),
    .read_buffer   (read_buffer),
    .read_addr     (read_addr),
    .read_data     (read_data),
    .vga_hsync     (vga_hsync),
    .vga_vsync     (vga_vsync),
    .vga_r         (vga_r),
    .vga_g         (vga_g),
    .vga_b         (vga_b)
  );

  always #5 clk = ~clk;

  // Pixel content of both buffers; source pixel 0 of buffer 1 is 0xABC.
  function automatic logic [11:0] pix(input logic b, input logic [AW-1:0] a);
    logic [11:0] t;
    t = 12'(a) * 12'd37;
    if (b) t = t + 12'h5A5;
    if (b && a == '0) t = 12'hABC;
    return t;
  endfunction

  // Registered BRAM: data valid one cycle after the address.
  always @(posedge clk) if (read_en) read_data <= pix(read_buffer, read_addr);

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Expected {hsync, vsync, rgb} produced by a given counter value.
  function automatic logic [13:0] pins_exp(input int h, input int v, input bit sel);
    bit vis;
    bit hs;
    bit vs;
    int a;
    vis = (h < HV) && (v < VV);
    hs  = !((h >= HV + HF) && (h < HV + HF + HS));
    vs  = !((v >= VV + VF) && (v < VV + VF + VS));
    a   = vis ? (h / SC + (v / SC) * BW) : 0;
    return {hs, vs, vis ? pix(!sel, AW'(a)) : 12'h000};
  endfunction

  // frame_done schedule: ignored in INIT, normal, double, on vblank_start, then
  // three idle frames, then one lost to a mid-frame reset.
  function automatic bit fd_at(input int f, input int v, input int h);
    return (f == 0 && v == 10 && h == 3) ||
           (f == 1 && v == 25 && h == 7) ||
           (f == 2 && (v == 5 || v == 30) && h == 0) ||
           (f == 3 && v == VV && h == 0) ||
           (f == 7 && v == 20 && h == 9);
  endfunction

  logic [13:0] pin_q[$];
  int  mh, mv, frame, mst;
  bit  msel, mpend;
  int  ds_cnt = 0;
  int  ack_cnt = 0;

  task automatic model_reset();
    mh = 0; mv = 0; mst = 0; msel = 1'b0; mpend = 1'b0;
    pin_q.delete();
    pin_q.push_back(14'h3000);
    pin_q.push_back(pins_exp(0, 0, 1'b0));
  endtask

  task automatic hold_reset(input int n);
    frame_done = 1'b0;
    rstn = 1'b0;
    #1;
    model_reset();
    repeat (n) begin
      @(negedge clk);
      check("rst_pins", 32'({vga_hsync, vga_vsync, vga_r, vga_g, vga_b}), 32'h3000);
      check("rst_read", 32'({read_en, read_addr}), 32'h0);
      check("rst_handshake", 32'({draw_start, draw_ack, buffer_select, read_buffer}), 32'b0001);
    end
    #2 rstn = 1'b1;
  endtask

  initial begin
    bit done = 1'b0;
    bit post = 1'b0;
    bit fd;
    bit vb;
    bit vis;
    int a;
    logic [13:0] exp_pins;

    frame_done = 1'b0;
    frame = 0;
    hold_reset(3);

    for (int cyc = 0; cyc < MAX_CYCLES && !done; cyc++) begin
      @(negedge clk);
      if (mh == HT - 1) begin
        mh = 0;
        if (mv == VT - 1) begin mv = 0; frame++; end
        else mv++;
      end else begin
        mh++;
      end

      if (!post && frame == 7 && mv == 30 && mh == 40) begin
        post  = 1'b1;
        frame = 0;
        hold_reset(3);
        continue;
      end

      vis = (mh < HV) && (mv < VV);
      a   = vis ? (mh / SC + (mv / SC) * BW) : 0;
      check("read_port", 32'({read_en, read_addr}), 32'({vis, AW'(a)}));

      pin_q.push_back(pins_exp(mh, mv, msel));
      exp_pins = pin_q.pop_front();
      check("pins", 32'({vga_hsync, vga_vsync, vga_r, vga_g, vga_b}), 32'(exp_pins));

      vb = (mh == 0) && (mv == VV);
      check("handshake", 32'({draw_start, draw_ack, buffer_select, read_buffer}),
            32'({(mst == 0) && vb, mst == 2, msel, !msel}));
      if (draw_start) ds_cnt++;
      if (draw_ack)   ack_cnt++;

      fd = fd_at(frame, mv, mh);
      frame_done = fd;

      case (mst)
        0: if (vb) mst = 1;
        1: begin
          if (vb && (mpend || fd)) begin mst = 2; msel = !msel; end
          if (fd) mpend = 1'b1;
        end
        default: begin mpend = 1'b0; mst = 1; end
      endcase

      if (post && frame == 0 && mv == VV + 2) done = 1'b1;
    end

    frame_done = 1'b0;
    if (!done) check("timeout", 32'(done), 32'd1);
    check("n_draw_start", 32'(ds_cnt), 32'd2);
    check("n_draw_ack", 32'(ack_cnt), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
